shift_req_arbiter: RTL and testbench

SHIFT_REQ_ARBITER -- requirements
Module: shift_req_arbiter

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_req_arbiter_shifter.sv | 22 ++
 rtl/shift_req_arbiter.sv | 133 +++++++++++++
 tb/tb_shift_req_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift request arbiter slice.
//   DATA_W  - operand/result width (only 16 supported)
//   AMT_W   - shift-amount width (only 4 supported)
//   state_t - arbiter FSM state encoding
package shift_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_req_arbiter_shifter.sv
// Combinational 16-bit logical shifter with zero fill.
// Ports:
//   i_a   - operand
//   i_amt - shift amount (0 passes i_a unchanged)
//   i_dir - 0 = left, 1 = right
//   o_y   - shifted result
module Shift_left_or_right_16bit
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [AMT_W-1:0]  i_amt,
  input  logic              i_dir,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    if (i_dir) o_y = i_a >> i_amt;
    else       o_y = i_a << i_amt;
  end

endmodule

// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin arbiter in front of one shared shifter.
// One operation is in flight at a time: IDLE (accept) -> SHIFT (compute)
// -> DONE (hold result until res_ready).
// Ports:
//   clk, reset_n            - clock, async active-low reset
//   reqN_valid/ready        - request handshake (ready only in IDLE, granted N)
//   reqN_data/amt/dir       - operand, shift amount, direction (1 = right)
//   res_valid/ready         - result handshake (valid exactly in DONE)
//   res_data, res_src       - shifted result and owning requester
//   busy                    - FSM not in IDLE
//   gnt_cnt0, gnt_cnt1      - saturating grant counters
module shift_req_arbiter #(
  parameter int unsigned DATA_W = shift_pkg::DATA_W,
  parameter int unsigned AMT_W  = shift_pkg::AMT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req0_dir,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic              req1_dir,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_src,
  output logic              busy,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1
);

  import shift_pkg::*;

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic [DATA_W-1:0] r_op_data;
  logic [AMT_W-1:0]  r_op_amt;
  logic              r_op_dir;
  logic              r_op_src;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_src;
  logic [7:0]        r_cnt0;
  logic [7:0]        r_cnt1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer0;
  logic              w_xfer1;
  logic [DATA_W-1:0] w_shift_y;

  // Tie goes to the requester not granted last (r_last = 1 -> req0 wins).
  assign w_gnt0 = req0_valid & (~req1_valid | r_last);
  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // reset_n gates ready directly so nothing is offered while reset is held.
  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = reset_n & w_gnt0;
        req1_ready = reset_n & w_gnt1;
        if (w_gnt0 | w_gnt1) w_next = SHIFT;
      end
      SHIFT: w_next = DONE;
      DONE:  if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_xfer0 = req0_valid & req0_ready;
  assign w_xfer1 = req1_valid & req1_ready;

  Shift_left_or_right_16bit u_shifter (
    .i_a   (r_op_data),
    .i_amt (r_op_amt),
    .i_dir (r_op_dir),
    .o_y   (w_shift_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= 1'b1;
      r_op_data  <= '0;
      r_op_amt   <= '0;
      r_op_dir   <= 1'b0;
      r_op_src   <= 1'b0;
      r_res_data <= '0;
      r_res_src  <= 1'b0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
    end else begin
      if (w_xfer0) begin
        r_op_data <= req0_data;
        r_op_amt  <= req0_amt;
        r_op_dir  <= req0_dir;
        r_op_src  <= 1'b0;
        r_last    <= 1'b0;
        if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + 8'd1;
      end else if (w_xfer1) begin
        r_op_data <= req1_data;
        r_op_amt  <= req1_amt;
        r_op_dir  <= req1_dir;
        r_op_src  <= 1'b1;
        r_last    <= 1'b1;
        if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + 8'd1;
      end
      if (r_state == SHIFT) begin
        r_res_data <= w_shift_y;
        r_res_src  <= r_op_src;
      end
    end
  end

  assign res_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign res_data  = r_res_data;
  assign res_src   = r_res_src;
  assign gnt_cnt0  = r_cnt0;
  assign gnt_cnt1  = r_cnt1;

endmodule

// File: tb/tb_shift_req_arbiter.sv
module tb_shift_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic        req0_dir, req1_dir;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_src;
  logic        busy;
  logic [7:0]  gnt_cnt0, gnt_cnt1;

  int checks   = 0;
  int failures = 0;
  int cycles   = 0;

  // Reference model state
  int m_last;
  int m_cnt0;
  int m_cnt1;

  shift_req_arbiter #(.DATA_W(16), .AMT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_shift(input logic [15:0] a, input int amt, input logic dir);
    int unsigned v;
    v = a;
    if (dir) v = v / (1 << amt);
    else     v = (v * (1 << amt)) % 65536;
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
    req0_dir = 1'b0; req1_dir = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    tick();
  endtask

  // One arbitration attempt starting in IDLE; wait_cyc = cycles res_ready held low in DONE.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic dr0, input logic dr1, input int wait_cyc);
    int g;
    logic [15:0] exp;
    req0_valid = v0; req1_valid = v1;
    req0_data = d0; req1_data = d1; req0_amt = a0; req1_amt = a1;
    req0_dir = dr0; req1_dir = dr1;
    res_ready = (wait_cyc == 0);
    #1;
    if (!v0 && !v1)     g = -1;
    else if (v0 && v1)  g = (m_last == 1) ? 0 : 1;
    else                g = v0 ? 0 : 1;
    checks++;
    if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
      failures++;
      $display("FAIL ready got=%b%b exp=%b%b", req0_ready, req1_ready, g == 0, g == 1);
    end
    tick();
    if (g < 0) begin
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold busy=%b res_valid=%b exp=0 0", busy, res_valid);
      end
      return;
    end
    m_last = g;
    if (g == 0) begin
      if (m_cnt0 < 255) m_cnt0++;
      exp = ref_shift(d0, a0, dr0);
    end else begin
      if (m_cnt1 < 255) m_cnt1++;
      exp = ref_shift(d1, a1, dr1);
    end
    // Scramble inputs: the operation must use the registered operands.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 16'($urandom); req1_data = 16'($urandom);
    req0_amt = 4'($urandom); req1_amt = 4'($urandom);
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL shift_state busy=%b res_valid=%b exp=1 0", busy, res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp || res_src !== g[0]) begin
      failures++;
      $display("FAIL result valid=%b data=%h src=%b exp=1 %h %0d", res_valid, res_data, res_src, exp, g);
    end
    for (int i = 0; i < wait_cyc; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL done_ready got=%b%b exp=00", req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== exp || res_src !== g[0]) begin
        failures++;
        $display("FAIL done_hold valid=%b busy=%b data=%h src=%b exp=1 1 %h %0d",
                 res_valid, busy, res_data, res_src, exp, g);
      end
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || gnt_cnt0 !== 8'(m_cnt0) || gnt_cnt1 !== 8'(m_cnt1)) begin
      failures++;
      $display("FAIL release busy=%b valid=%b cnt=%0d/%0d exp=0 0 %0d/%0d",
               busy, res_valid, gnt_cnt0, gnt_cnt1, m_cnt0, m_cnt1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
    req0_data = 16'h1234; req1_data = 16'h5678; req0_amt = 4'd1; req1_amt = 4'd2;
    req0_dir = 1'b0; req1_dir = 1'b1;
    #3;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
        res_data !== 16'h0 || res_src !== 1'b0 || gnt_cnt0 !== 8'd0 || gnt_cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL reset rdy=%b%b busy=%b valid=%b data=%h src=%b cnt=%0d/%0d exp=all zero",
               req0_ready, req1_ready, busy, res_valid, res_data, res_src, gnt_cnt0, gnt_cnt1);
    end
    apply_reset();
  endtask

  task automatic test_directed();
    run_op(1'b1, 1'b0, 16'h8001, 16'h0, 4'd1, 4'd0, 1'b0, 1'b0, 0);
    run_op(1'b0, 1'b1, 16'h0, 16'hF000, 4'd0, 4'd4, 1'b0, 1'b1, 0);
    run_op(1'b1, 1'b0, 16'hA5A5, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 5);
    run_op(1'b0, 1'b1, 16'h0, 16'hA5A5, 4'd0, 4'd0, 1'b0, 1'b0, 1);
    run_op(1'b1, 1'b0, 16'hFFFF, 16'h0, 4'd15, 4'd0, 1'b1, 1'b0, 0);
    run_op(1'b1, 1'b0, 16'hFFFF, 16'h0, 4'd15, 4'd0, 1'b0, 1'b0, 0);
    run_op(1'b0, 1'b0, 16'h1111, 16'h2222, 4'd3, 4'd3, 1'b0, 1'b0, 0);
  endtask

  task automatic test_alternate();
    int start;
    apply_reset();
    start = cycles;
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 1'b1, 16'(16'h0101 << i), 16'h8080, 4'(i), 4'(i + 1), 1'b0, 1'b1, 0);
    checks++;
    if (gnt_cnt0 !== 8'd2 || gnt_cnt1 !== 8'd2) begin
      failures++;
      $display("FAIL alternate_cnt got=%0d/%0d exp=2/2", gnt_cnt0, gnt_cnt1);
    end
    checks++;
    if (cycles - start != 12) begin
      failures++;
      $display("FAIL throughput cycles=%0d exp=12", cycles - start);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++)
      run_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_in_shift();
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = 16'hBEEF; req0_amt = 4'd2; req0_dir = 1'b0; res_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_shift_enter busy=%b exp=1", busy);
    end
    req1_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0 || res_src !== 1'b0 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0 || gnt_cnt0 !== 8'd0 || gnt_cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL rst_shift busy=%b valid=%b data=%h src=%b rdy=%b%b cnt=%0d/%0d exp=all zero",
               busy, res_valid, res_data, res_src, req0_ready, req1_ready, gnt_cnt0, gnt_cnt1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_result valid=%b busy=%b exp=0 0", res_valid, busy);
      end
    end
    res_ready = 1'b0;
    // Tie after reset goes to req0 again.
    run_op(1'b1, 1'b1, 16'h0003, 16'h0C00, 4'd2, 4'd2, 1'b0, 1'b1, 0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++)
      run_op(1'b1, 1'b0, 16'($urandom), 16'h0, 4'($urandom), 4'd0, 1'($urandom), 1'b0, 0);
    checks++;
    if (gnt_cnt0 !== 8'd255) begin
      failures++;
      $display("FAIL saturate got=%0d exp=255", gnt_cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_alternate();
    test_random();
    test_reset_in_shift();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
